// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, lane-steered stores, extended loads,
// fixed-latency memory access with a registered one-cycle response.
module load_store_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_misaligned,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_we,
    input  logic [31:0] i_mem_rdata
);

    // state    | meaning
    // S_IDLE   | ready for a request, no memory activity
    // S_ACCESS | memory addressed, waiting MEM_LATENCY cycles
    // S_RESP   | one-cycle response pulse on resp_*
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Terminal count is zero, so the counter loads latency-1.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_lat_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_mis;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_we;

    logic        w_hs;
    logic        w_err;
    logic [3:0]  w_we_lanes;
    logic [31:0] w_wdata_lanes;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_hs = i_req_valid & r_req_ready;

    always_comb begin
        w_err         = 1'b0;
        w_we_lanes    = 4'b0000;
        w_wdata_lanes = 32'h0;
        case (i_req_size)
            SZ_BYTE: begin
                w_we_lanes    = 4'b0001 << i_req_addr[1:0];
                w_wdata_lanes = {4{i_req_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_err         = i_req_addr[0];
                w_we_lanes    = i_req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_lanes = {2{i_req_wdata[15:0]}};
            end
            SZ_WORD: begin
                w_err         = (i_req_addr[1:0] != 2'b00);
                w_we_lanes    = 4'b1111;
                w_wdata_lanes = i_req_wdata;
            end
            default: w_err = 1'b1;
        endcase
    end

    assign w_byte = i_mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = i_mem_rdata[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = i_mem_rdata;
        case (r_size)
            SZ_BYTE: w_load_data = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_load_data = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= 4'd0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_lane       <= 2'b00;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_mis   <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_we     <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_req_ready <= 1'b0;
                        r_we        <= i_req_we;
                        r_size      <= i_req_size;
                        r_unsigned  <= i_req_unsigned;
                        r_lane      <= i_req_addr[1:0];
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_mis   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else begin
                            r_state     <= S_ACCESS;
                            r_lat_cnt   <= LAT_LOAD;
                            r_mem_addr  <= {i_req_addr[31:2], 2'b00};
                            r_mem_we    <= i_req_we ? w_we_lanes : 4'b0000;
                            r_mem_wdata <= i_req_we ? w_wdata_lanes : 32'h0;
                        end
                    end
                end
                S_ACCESS: begin
                    // Write strobe lasts only the first access cycle.
                    r_mem_we <= 4'b0000;
                    if (r_lat_cnt == 4'd0) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_we ? 32'h0 : w_load_data;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'h0;
                    r_resp_mis   <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready       = r_req_ready;
    assign o_resp_valid      = r_resp_valid;
    assign o_resp_rdata      = r_resp_rdata;
    assign o_resp_misaligned = r_resp_mis;
    assign o_mem_addr        = r_mem_addr;
    assign o_mem_wdata       = r_mem_wdata;
    assign o_mem_we          = r_mem_we;

endmodule
